// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial MSB-first pattern transmitter with repeat count and
// inter-frame gap, feeding the single-bit input of a sequence detector.
module seq_pattern_gen #(
   parameter int   PAT_W      = 8,
   parameter int   LEN_W      = 4,
   parameter int   CNT_W      = 4,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [LEN_W-1:0] pat_len,
   input  logic [CNT_W-1:0] repeat_cnt,
   input  logic [CNT_W-1:0] gap_len,
   output logic             sequence_out,
   output logic             bit_valid,
   output logic             frame_start,
   output logic             busy,
   output logic             done
);

   localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

   state_t             state_q, state_d;
   logic [PAT_W-1:0]   pat_q, pat_d;       // captured frame bits
   logic [IDX_W-1:0]   top_q, top_d;       // L-1, index of first bit sent
   logic [IDX_W-1:0]   bit_q, bit_d;       // index of bit currently on the wire
   logic [CNT_W-1:0]   frm_q, frm_d;       // frames remaining, including current
   logic [CNT_W-1:0]   glen_q, glen_d;     // captured gap length G
   logic [CNT_W-1:0]   gap_q, gap_d;       // gap cycles remaining, including current
   logic               seq_q, seq_d;
   logic               vld_q, vld_d;
   logic               fs_q, fs_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   int                 len_int;
   logic [IDX_W-1:0]   top_cap;
   logic [CNT_W-1:0]   frm_cap;

   assign sequence_out = seq_q;
   assign bit_valid    = vld_q;
   assign frame_start  = fs_q;
   assign busy         = busy_q;
   assign done         = done_q;

   // Clamp the requested length and frame count into their legal ranges.
   always_comb begin
      len_int = 32'(pat_len);
      if (len_int == 0)
         top_cap = '0;
      else if (len_int > PAT_W)
         top_cap = IDX_W'(PAT_W - 1);
      else
         top_cap = IDX_W'(len_int - 1);
      frm_cap = (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;
   end

   // Next-state and registered-output logic; each branch sets what the wire shows next cycle.
   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      top_d   = top_q;
      bit_d   = bit_q;
      frm_d   = frm_q;
      glen_d  = glen_q;
      gap_d   = gap_q;
      seq_d   = IDLE_LEVEL;
      vld_d   = 1'b0;
      fs_d    = 1'b0;
      busy_d  = busy_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               state_d = SHIFT;
               pat_d   = pattern;
               top_d   = top_cap;
               bit_d   = top_cap;
               frm_d   = frm_cap;
               glen_d  = gap_len;
               seq_d   = pattern[top_cap];
               vld_d   = 1'b1;
               fs_d    = 1'b1;
               busy_d  = 1'b1;
            end
         end
         SHIFT: begin
            if (bit_q != '0) begin
               bit_d = bit_q - IDX_W'(1);
               seq_d = pat_q[bit_q - IDX_W'(1)];
               vld_d = 1'b1;
            end else if (frm_q > CNT_W'(1)) begin
               frm_d = frm_q - CNT_W'(1);
               if (glen_q != '0) begin
                  state_d = GAP;
                  gap_d   = glen_q;
               end else begin
                  bit_d = top_q;
                  seq_d = pat_q[top_q];
                  vld_d = 1'b1;
                  fs_d  = 1'b1;
               end
            end else begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         GAP: begin
            if (gap_q > CNT_W'(1)) begin
               gap_d = gap_q - CNT_W'(1);
            end else begin
               state_d = SHIFT;
               bit_d   = top_q;
               seq_d   = pat_q[top_q];
               vld_d   = 1'b1;
               fs_d    = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any transfer without a done pulse.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         pat_q   <= '0;
         top_q   <= '0;
         bit_q   <= '0;
         frm_q   <= '0;
         glen_q  <= '0;
         gap_q   <= '0;
         seq_q   <= IDLE_LEVEL;
         vld_q   <= 1'b0;
         fs_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         top_q   <= top_d;
         bit_q   <= bit_d;
         frm_q   <= frm_d;
         glen_q  <= glen_d;
         gap_q   <= gap_d;
         seq_q   <= seq_d;
         vld_q   <= vld_d;
         fs_q    <= fs_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

endmodule
